// File: rtl/vcve2_pkg.sv
// Shared vector-unit types: register group multiplier encoding (vtype.vlmul).
package vcve2_pkg;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

endpackage

// File: rtl/vcve2_vrf_agu.sv
// Address generator for vector-register-file words held in data memory.
// Optional group-bounds checking is enabled with `define VCVE2_AGU_BOUNDS_CHK_EN.
//
// state  | meaning
// IDLE   | no group in progress; get/incr requests ignored
// ACTIVE | operands latched; addresses generated, offsets advance on incr
module vcve2_vrf_agu #(
  parameter int unsigned VLEN     = 128,
  parameter logic [31:0] VRF_BASE = 32'h0000_1000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               agu_load_i,
  input  logic               agu_get_rs1_i,
  input  logic               agu_get_rs2_i,
  input  logic               agu_get_rd_i,
  input  logic               agu_incr_i,
  input  logic [4:0]         vs1_i,
  input  logic [4:0]         vs2_i,
  input  logic [4:0]         vd_i,
  input  vcve2_pkg::vlmul_e  lmul_i,
  output logic [31:0]        addr_o,
  output logic               addr_valid_o,
  output logic               group_end_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned VLENB = VLEN / 8;
  localparam int unsigned OFF_W = $clog2(8 * VLENB) + 1;

  typedef enum logic {IDLE, ACTIVE} state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_RS1, SEL_RS2, SEL_RD} sel_e;

  state_e           state_q;
  logic [4:0]       vs1_q, vs2_q, vd_q;
  logic [2:0]       lmul_q;
  logic [OFF_W-1:0] off_rs1_q, off_rs2_q, off_rd_q;
  logic [31:0]      addr_q;
  logic             addr_valid_q;
  logic             group_end_q;
  logic             err_d;

  sel_e             sel;
  logic [4:0]       sel_idx;
  logic [OFF_W-1:0] sel_off;
  logic [OFF_W-1:0] off_inc;
  logic [OFF_W-1:0] off_nxt;
  logic [OFF_W-1:0] gb;
  logic             wrap;
  logic [31:0]      sel_addr;

  // On a load cycle the address comes from the incoming indices at offset 0.
  always_comb begin
    sel = SEL_NONE;
    if (agu_get_rs1_i)      sel = SEL_RS1;
    else if (agu_get_rs2_i) sel = SEL_RS2;
    else if (agu_get_rd_i)  sel = SEL_RD;

    sel_idx = '0;
    sel_off = '0;
    case (sel)
      SEL_RS1: begin
        sel_idx = agu_load_i ? vs1_i : vs1_q;
        sel_off = off_rs1_q;
      end
      SEL_RS2: begin
        sel_idx = agu_load_i ? vs2_i : vs2_q;
        sel_off = off_rs2_q;
      end
      SEL_RD: begin
        sel_idx = agu_load_i ? vd_i : vd_q;
        sel_off = off_rd_q;
      end
      default: ;
    endcase
    if (agu_load_i) sel_off = '0;
  end

  assign gb       = lmul_q[2] ? OFF_W'(VLENB) : OFF_W'(VLENB) << lmul_q[1:0];
  assign off_inc  = sel_off + OFF_W'(4);
  assign wrap     = (off_inc == gb);
  assign off_nxt  = wrap ? '0 : off_inc;
  assign sel_addr = VRF_BASE + (32'(sel_idx) * VLENB) + 32'(sel_off);

`ifdef VCVE2_AGU_BOUNDS_CHK_EN
  logic err_q;

  // Fractional and reserved multipliers occupy a single register: always legal.
  function automatic logic idx_bad(input logic [4:0] idx, input logic [2:0] lmul);
    logic [3:0] n;
    idx_bad = 1'b0;
    if (!lmul[2]) begin
      n = 4'd1 << lmul[1:0];
      idx_bad = ((idx & {1'b0, n - 4'd1}) != 5'd0) ||
                (({1'b0, idx} + {2'b00, n}) > 6'd32);
    end
  endfunction

  assign err_d = agu_load_i ? (idx_bad(vs1_i, lmul_i) | idx_bad(vs2_i, lmul_i) |
                               idx_bad(vd_i, lmul_i))
                            : err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_d = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      lmul_q       <= '0;
      off_rs1_q    <= '0;
      off_rs2_q    <= '0;
      off_rd_q     <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      group_end_q  <= 1'b0;
    end else begin
      addr_valid_q <= 1'b0;
      group_end_q  <= 1'b0;
      if (agu_load_i) begin
        state_q   <= ACTIVE;
        vs1_q     <= vs1_i;
        vs2_q     <= vs2_i;
        vd_q      <= vd_i;
        lmul_q    <= lmul_i;
        off_rs1_q <= '0;
        off_rs2_q <= '0;
        off_rd_q  <= '0;
        if (sel != SEL_NONE) begin
          addr_q       <= sel_addr;
          addr_valid_q <= ~err_d;
        end
      end else begin
        case (state_q)
          IDLE: ;
          ACTIVE: begin
            if (sel != SEL_NONE) begin
              addr_q       <= sel_addr;
              addr_valid_q <= ~err_d;
              if (agu_incr_i) begin
                case (sel)
                  SEL_RS1: off_rs1_q <= off_nxt;
                  SEL_RS2: off_rs2_q <= off_nxt;
                  SEL_RD: begin
                    off_rd_q <= off_nxt;
                    if (wrap) begin
                      group_end_q <= 1'b1;
                      state_q     <= IDLE;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = addr_valid_q;
  assign group_end_o  = group_end_q;
  assign busy_o       = (state_q == ACTIVE);

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Self-checking bench for vcve2_vrf_agu: directed scenarios plus random traffic
// compared against a per-operand offset model.
module tb_vcve2_vrf_agu;
  import vcve2_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        agu_load_i, agu_get_rs1_i, agu_get_rs2_i, agu_get_rd_i, agu_incr_i;
  logic [4:0]  vs1_i, vs2_i, vd_i;
  vlmul_e      lmul_i;
  logic [31:0] addr_o;
  logic        addr_valid_o, group_end_o, busy_o, err_o;

  vcve2_vrf_agu #(.VLEN(128), .VRF_BASE(32'h0000_1000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .agu_load_i(agu_load_i), .agu_get_rs1_i(agu_get_rs1_i),
    .agu_get_rs2_i(agu_get_rs2_i), .agu_get_rd_i(agu_get_rd_i),
    .agu_incr_i(agu_incr_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
    .lmul_i(lmul_i), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
    .group_end_o(group_end_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int gend_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: one byte offset per operand, indices and multiplier as ints.
  int          m_idx[3];
  int          m_off[3];
  int          m_lmul;
  bit          m_act;
  bit          m_err;
  logic [31:0] e_addr;
  bit          e_valid, e_gend;

  function automatic int group_bytes();
    return (m_lmul < 4) ? (16 << m_lmul) : 16;
  endfunction

  function automatic logic [31:0] addr_of(input int s);
    return 32'h1000 + 32'(m_idx[s] * 16 + m_off[s]);
  endfunction

  function automatic bit bounds_err();
    bit e = 0;
`ifdef VCVE2_AGU_BOUNDS_CHK_EN
    if (m_lmul < 4) begin
      int n = 1 << m_lmul;
      for (int k = 0; k < 3; k++)
        if ((m_idx[k] % n) != 0 || (m_idx[k] + n) > 32) e = 1;
    end
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0;
      m_off[k] = 0;
    end
    m_lmul = 0; m_act = 0; m_err = 0;
    e_addr = 32'h0; e_valid = 0; e_gend = 0;
  endtask

  task automatic model_step();
    int s;
    s = agu_get_rs1_i ? 0 : agu_get_rs2_i ? 1 : agu_get_rd_i ? 2 : -1;
    e_valid = 0;
    e_gend  = 0;
    if (agu_load_i) begin
      m_idx[0] = int'(vs1_i); m_idx[1] = int'(vs2_i); m_idx[2] = int'(vd_i);
      for (int k = 0; k < 3; k++) m_off[k] = 0;
      m_lmul = int'(lmul_i);
      m_act  = 1;
      m_err  = bounds_err();
      if (s >= 0) begin
        e_addr  = addr_of(s);
        e_valid = !m_err;
      end
    end else if (m_act && s >= 0) begin
      e_addr  = addr_of(s);
      e_valid = !m_err;
      if (agu_incr_i) begin
        m_off[s] += 4;
        if (m_off[s] == group_bytes()) begin
          m_off[s] = 0;
          if (s == 2) begin
            e_gend = 1;
            m_act  = 0;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit ld, input bit g1, input bit g2, input bit gd, input bit inc);
    agu_load_i    = ld;
    agu_get_rs1_i = g1;
    agu_get_rs2_i = g2;
    agu_get_rd_i  = gd;
    agu_incr_i    = inc;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    if (group_end_o) gend_cnt++;
    check({tag, "_busy"},  32'(busy_o),       32'(m_act));
    check({tag, "_valid"}, 32'(addr_valid_o), 32'(e_valid));
    check({tag, "_gend"},  32'(group_end_o),  32'(e_gend));
    check({tag, "_err"},   32'(err_o),        32'(m_err));
    if (e_valid) check({tag, "_addr"}, addr_o, e_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0);
    vs1_i = '0; vs2_i = '0; vd_i = '0; lmul_i = LMUL_1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_addr",  addr_o, 32'h0);
    check("rst_valid", 32'(addr_valid_o), 32'h0);
    check("rst_busy",  32'(busy_o), 32'h0);
    check("rst_gend",  32'(group_end_o), 32'h0);
    check("rst_err",   32'(err_o), 32'h0);
    rst_ni = 1'b1;

    // Idle after reset: get requests are ignored.
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("idle");
      check("idle_addr", addr_o, 32'h0);
    end

    // Basic operand addressing, LMUL 1.
    vs1_i = 5'd3; vs2_i = 5'd5; vd_i = 5'd7; lmul_i = LMUL_1;
    drive(1, 0, 0, 0, 0); cycle("ld1");
    drive(0, 1, 0, 0, 0); cycle("rs1"); check("rs1_addr", addr_o, 32'h1030);
    drive(0, 0, 1, 0, 0); cycle("rs2"); check("rs2_addr", addr_o, 32'h1050);
    drive(0, 0, 0, 1, 0); cycle("rd");  check("rd_addr",  addr_o, 32'h1070);
    drive(0, 0, 0, 0, 1); cycle("incr_nosel");

    // Walk vd through its group.
    g0 = gend_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1); cycle("walk1");
      check("walk1_addr", addr_o, 32'h1070 + 32'(4 * i));
    end
    check("walk1_gend_last", 32'(group_end_o), 32'h1);
    drive(0, 0, 0, 1, 1); cycle("after_end");
    drive(0, 0, 0, 0, 0); cycle("after_end2");
    check("walk1_gend_once", 32'(gend_cnt - g0), 32'h1);
    check("walk1_busy", 32'(busy_o), 32'h0);

    // LMUL 2 group on vd=4; rs1 offset stays at its base.
    vs1_i = 5'd2; vs2_i = 5'd0; vd_i = 5'd4; lmul_i = LMUL_2;
    drive(1, 0, 0, 0, 0); cycle("ld2");
    g0 = gend_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 1); cycle("walk2");
      check("walk2_addr", addr_o, 32'h1040 + 32'(4 * i));
      if (i == 4) begin
        drive(0, 1, 0, 0, 0); cycle("walk2_rs1");
        check("walk2_rs1_addr", addr_o, 32'h1020);
      end
    end
    check("walk2_last_addr", addr_o, 32'h105C);
    check("walk2_gend", 32'(gend_cnt - g0), 32'h1);

    // Load beats incr mid-group; priority rs1 > rs2 > rd; load + get.
    vs1_i = 5'd3; vs2_i = 5'd5; vd_i = 5'd7; lmul_i = LMUL_1;
    drive(1, 0, 0, 0, 0); cycle("ld3");
    drive(0, 0, 0, 1, 1); cycle("mid1");
    drive(0, 0, 0, 1, 1); cycle("mid2");
    vs1_i = 5'd1; vd_i = 5'd9;
    drive(1, 0, 0, 0, 1); cycle("ld_incr");
    vs1_i = 5'd20; vd_i = 5'd21;
    drive(0, 0, 0, 1, 0); cycle("ld_incr_rd"); check("ld_incr_rd_addr", addr_o, 32'h1090);
    drive(0, 1, 1, 1, 1); cycle("prio");       check("prio_addr", addr_o, 32'h1010);
    drive(0, 0, 1, 1, 0); cycle("prio2");      check("prio2_addr", addr_o, 32'h1050);
    vs2_i = 5'd10;
    drive(1, 0, 1, 0, 0); cycle("ld_get");     check("ld_get_addr", addr_o, 32'h10A0);

    // Group-bounds handling for LMUL 4, vd=6.
    vs1_i = 5'd0; vs2_i = 5'd4; vd_i = 5'd6; lmul_i = LMUL_4;
    drive(1, 0, 0, 0, 0); cycle("bnd_ld");
    drive(0, 0, 0, 1, 0); cycle("bnd_rd");
`ifdef VCVE2_AGU_BOUNDS_CHK_EN
    check("bnd_err_set", 32'(err_o), 32'h1);
    check("bnd_valid_low", 32'(addr_valid_o), 32'h0);
    vd_i = 5'd8;
    drive(1, 0, 0, 0, 0); cycle("bnd_reld");
    drive(0, 0, 0, 1, 0); cycle("bnd_rd2");
    check("bnd_err_clr", 32'(err_o), 32'h0);
    check("bnd_addr2", addr_o, 32'h1080);
`else
    check("bnd_err_zero", 32'(err_o), 32'h0);
    check("bnd_addr", addr_o, 32'h1060);
`endif

    // Asynchronous reset mid-group aborts with no later group end.
    vs1_i = 5'd0; vs2_i = 5'd0; vd_i = 5'd0; lmul_i = LMUL_1;
    drive(1, 0, 0, 0, 0); cycle("ar_ld");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1); cycle("ar_walk");
    end
    #2 rst_ni = 1'b0;
    #1;
    check("ar_busy",  32'(busy_o), 32'h0);
    check("ar_valid", 32'(addr_valid_o), 32'h0);
    check("ar_addr",  addr_o, 32'h0);
    model_reset();
    drive(0, 0, 0, 1, 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    g0 = gend_cnt;
    for (int i = 0; i < 4; i++) cycle("ar_post");
    check("ar_no_gend", 32'(gend_cnt - g0), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      vs1_i  = 5'($urandom_range(0, 31));
      vs2_i  = 5'($urandom_range(0, 31));
      vd_i   = 5'($urandom_range(0, 31));
      lmul_i = vlmul_e'(3'($urandom_range(0, 7)));
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vcve2_vrf_agu.md
VCVE2_VRF_AGU -- requirements
Module: vcve2_vrf_agu

Interface
REQ-001 Parameters: VLEN, default 128, vector register length in bits; VLENB = VLEN/8.
REQ-002 Parameter: VRF_BASE, default 32'h0000_1000, byte base address of v0 in data memory.
REQ-003 clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 agu_load_i  in  1  latch vs1_i/vs2_i/vd_i/lmul_i and clear all offsets.
REQ-005 agu_get_rs1_i, agu_get_rs2_i, agu_get_rd_i  in  1 each  select the operand whose address is presented next cycle.
REQ-006 agu_incr_i  in  1  advance the offset of the operand selected in the same cycle by 4 bytes.
REQ-007 vs1_i, vs2_i, vd_i  in  5 each  vector register indices; lmul_i  in  vcve2_pkg::vlmul_e  register group multiplier.
REQ-008 addr_o  out  32  word address to the VRF memory port; addr_valid_o  out  1  addr_o is meaningful.
REQ-009 group_end_o  out  1  one-cycle pulse: vd offset wrapped at the end of the register group.
REQ-010 busy_o  out  1  FSM is in ACTIVE; err_o  out  1  register-group error (see Configuration).

Function
REQ-011 FSM states IDLE and ACTIVE; agu_load_i in any state -> ACTIVE with offsets cleared.
REQ-012 ACTIVE -> IDLE on the cycle group_end_o is asserted; agu_get_*/agu_incr_i are ignored in IDLE.
REQ-013 Group bytes GB = VLENB << lmul for lmul encodings 3'b000..3'b011 (LMUL 1,2,4,8); GB = VLENB for all fractional/reserved encodings.
REQ-014 Per-operand address = VRF_BASE + idx*VLENB + off, computed modulo 2^32; off width = $clog2(8*VLENB)+1 bits.
REQ-015 Select priority when several agu_get_* are high: rs1 > rs2 > rd.
REQ-016 Latency: addr_o and addr_valid_o are registered; they reflect the selection of cycle N in cycle N+1 using the offset value before any increment of cycle N.
REQ-017 addr_valid_o is low in any cycle following a cycle with no agu_get_* high, or while in IDLE.
REQ-018 agu_incr_i with no agu_get_* high: no offset changes.
REQ-019 Offset reaching GB wraps to 0; for vd, the wrap asserts group_end_o in the following cycle; rs1/rs2 wrap silently.
REQ-020 agu_load_i and agu_incr_i in the same cycle: load wins, offsets are 0 afterwards.
REQ-021 agu_load_i together with agu_get_*: addr_o next cycle uses the newly loaded index with offset 0.
REQ-022 Operand indices and lmul are held stable from load until the next load, independent of input changes.

Reset
REQ-023 Reset forces IDLE, all offsets and latched indices to 0, addr_o=32'h0, addr_valid_o=0, group_end_o=0, busy_o=0, err_o=0.
REQ-024 Reset asserted mid-operation aborts immediately; no group_end_o pulse is produced after deassertion.

Configuration
REQ-025 Macro VCVE2_AGU_BOUNDS_CHK_EN defined: at agu_load_i, err_o is set if any index is not a multiple of LMUL or index+LMUL > 32 (integer LMUL only); err_o is held until the next load, and addr_valid_o is forced low while err_o is high.
REQ-026 Macro not defined: the check logic is absent, err_o is tied to 0, and addresses are generated for any index.

Verification
REQ-027 Reset then idle: addr_o=0, addr_valid_o=0, busy_o=0 for 10 cycles despite agu_get_rs1_i=1.
REQ-028 VLEN=128, load vs1=3, vs2=5, vd=7, LMUL1; get_rs1 -> next cycle addr_o=0x1030, valid=1; get_rs2 -> 0x1050; get_rd -> 0x1070.
REQ-029 Same config, 4x (get_rd+incr) -> addresses 0x1070, 0x1074, 0x1078, 0x107C; group_end_o pulses once; busy_o drops to 0.
REQ-030 LMUL2, vd=4: 8 incr on rd -> last addr_o=0x105C, then group_end_o; vs1 offset untouched: get_rs1 before group end still yields base.
REQ-031 Load asserted together with incr mid-group -> next get_rd returns idx*16+0x1000 (offset 0); all get_* high -> rs1 address.
REQ-032 With VCVE2_AGU_BOUNDS_CHK_EN: LMUL4, vd=6 -> err_o=1, addr_valid_o=0; reload with vd=8 -> err_o=0; without the macro, vd=6 -> err_o=0 and addr_o=0x1060.
